// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field positions, result-source codes,
// the packed control bundle, and the control/immediate decoders.
package decode_pkg;

  localparam int OP_LSB  = 0;
  localparam int F3_LSB  = 3;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 11;
  localparam int RS2_LSB = 16;
  localparam int F11_LSB = 21;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_PASS_B = 3'd7;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_ALUI   = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JAL    = 3'd5,
    OP_JALR   = 3'd6,
    OP_LUI    = 3'd7
  } opcode_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       jump_cond;
    logic       alu_src;
    logic [2:0] jump_cond_type;
    logic [2:0] alu_control;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic ctrl_t control_unit(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (opcode_t'(instr[OP_LSB +: 3]))
      OP_ALU:    begin c.reg_write = 1'b1; c.alu_control = instr[F3_LSB +: 3]; end
      OP_ALUI:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_control = instr[F3_LSB +: 3]; end
      OP_LOAD:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = RES_MEM; end
      OP_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      OP_BRANCH: begin
        c.jump_cond      = 1'b1;
        c.jump_cond_type = instr[F3_LSB +: 3];
        c.alu_control    = ALU_SUB;
      end
      OP_JAL:    begin c.jump = 1'b1; c.reg_write = 1'b1; c.result_src = RES_PC4; end
      OP_JALR:   begin c.jump = 1'b1; c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = RES_PC4; end
      OP_LUI:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_control = ALU_PASS_B; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Stores and branches split their immediate around the rd field.
  function automatic logic [31:0] imm_extend(input logic [31:0] instr);
    logic [31:0] imm;
    imm = '0;
    case (opcode_t'(instr[OP_LSB +: 3]))
      OP_ALUI, OP_LOAD, OP_JALR: imm = {{16{instr[31]}}, instr[31:16]};
      OP_STORE, OP_BRANCH:       imm = {{16{instr[31]}}, instr[31:21], instr[10:6]};
      OP_JAL:                    imm = {{11{instr[31]}}, instr[31:11]};
      OP_LUI:                    imm = {instr[31:11], 11'b0};
      default:                   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Two-read/one-write register file with hard-wired x0 and same-cycle
// write-through from the writeback port to both read ports.
module decode_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] mem [NUM_REGS];
  logic [AW-1:0]   wa_i, ra1_i, ra2_i;
  logic            wr_live;

  assign wa_i    = wa[AW-1:0];
  assign ra1_i   = ra1[AW-1:0];
  assign ra2_i   = ra2[AW-1:0];
  assign wr_live = we && (wa_i != '0);

  always_ff @(posedge clk) begin
    if (wr_live) mem[wa_i] <= wd;
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1_i != '0) rd1 = (wr_live && wa_i == ra1_i) ? wd : mem[ra1_i];
    if (ra2_i != '0) rd2 = (wr_live && wa_i == ra2_i) ? wd : mem[ra2_i];
  end

endmodule

// File: rtl/stage_decode_hs.sv
// Decode stage with valid/ready handshake into the DE/EX register.
// Define DECODE_LOAD_INTERLOCK_EN to stall internally on load-use hazards.
module stage_decode_hs
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            de_valid,
  output logic            de_ready,
  input  logic [31:0]     de_instr,
  input  logic [XLEN-1:0] de_pc,
  input  logic [XLEN-1:0] de_pc_plus4,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  input  logic            ex_clear,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_write,
  output logic            ex_jump,
  output logic            ex_jump_cond,
  output logic            ex_alu_src,
  output logic [2:0]      ex_jump_cond_type,
  output logic [2:0]      ex_alu_control,
  output logic [1:0]      ex_result_src,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc_plus_4,
  output logic [XLEN-1:0] ex_imm_ext,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      de_rs1,
  output logic [4:0]      de_rs2
);

  localparam int AW = $clog2(NUM_REGS);

  logic [4:0]      rd_field;
  ctrl_t           ctrl_dec, ctrl_q, ctrl_n;
  logic [XLEN-1:0] imm_dec, rf_rd1, rf_rd2;
  logic            load, interlock, capture, fwd1, fwd2, valid_n;
  logic [XLEN-1:0] pc_n, pc4_n, imm_n, rd1_n, rd2_n;
  logic [4:0]      rd_n, rs1_n, rs2_n;

  assign rd_field = de_instr[RD_LSB +: 5];
  assign de_rs1   = de_instr[RS1_LSB +: 5];
  assign de_rs2   = de_instr[RS2_LSB +: 5];
  assign ctrl_dec = control_unit(de_instr);
  assign imm_dec  = XLEN'($signed(imm_extend(de_instr)));

  decode_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk (clk),
    .we  (wb_reg_write),
    .wa  (wb_rd),
    .wd  (wb_result),
    .ra1 (de_rs1),
    .ra2 (de_rs2),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

`ifdef DECODE_LOAD_INTERLOCK_EN
  assign interlock = !ex_clear && de_valid && ex_valid && ctrl_q.reg_write &&
                     (ctrl_q.result_src == RES_MEM) && (ex_rd != 5'd0) &&
                     ((ex_rd == de_rs1) || (ex_rd == de_rs2));
`else
  assign interlock = 1'b0;
`endif

  assign load     = !ex_valid || ex_ready;
  assign de_ready = load && !interlock;
  assign capture  = load && de_valid && !interlock;

  // A stalled instruction must still see writebacks to its own sources.
  assign fwd1 = wb_reg_write && (wb_rd[AW-1:0] != '0) && (wb_rd[AW-1:0] == ex_rs1[AW-1:0]);
  assign fwd2 = wb_reg_write && (wb_rd[AW-1:0] != '0) && (wb_rd[AW-1:0] == ex_rs2[AW-1:0]);

  always_comb begin
    valid_n = ex_valid;
    ctrl_n  = ctrl_q;
    pc_n    = ex_pc;
    pc4_n   = ex_pc_plus_4;
    imm_n   = ex_imm_ext;
    rd1_n   = ex_rd1;
    rd2_n   = ex_rd2;
    rd_n    = ex_rd;
    rs1_n   = ex_rs1;
    rs2_n   = ex_rs2;
    if (ex_clear || (load && !capture)) begin
      valid_n = 1'b0;
      ctrl_n  = '0;
      pc_n    = '0;
      pc4_n   = '0;
      imm_n   = '0;
      rd1_n   = '0;
      rd2_n   = '0;
      rd_n    = '0;
      rs1_n   = '0;
      rs2_n   = '0;
    end else if (capture) begin
      valid_n = 1'b1;
      ctrl_n  = ctrl_dec;
      pc_n    = de_pc;
      pc4_n   = de_pc_plus4;
      imm_n   = imm_dec;
      rd1_n   = rf_rd1;
      rd2_n   = rf_rd2;
      rd_n    = rd_field;
      rs1_n   = de_rs1;
      rs2_n   = de_rs2;
    end else begin
      if (fwd1) rd1_n = wb_result;
      if (fwd2) rd2_n = wb_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ctrl_q       <= '0;
      ex_pc        <= '0;
      ex_pc_plus_4 <= '0;
      ex_imm_ext   <= '0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
    end else begin
      ex_valid     <= valid_n;
      ctrl_q       <= ctrl_n;
      ex_pc        <= pc_n;
      ex_pc_plus_4 <= pc4_n;
      ex_imm_ext   <= imm_n;
      ex_rd1       <= rd1_n;
      ex_rd2       <= rd2_n;
      ex_rd        <= rd_n;
      ex_rs1       <= rs1_n;
      ex_rs2       <= rs2_n;
    end
  end

  assign ex_reg_write      = ctrl_q.reg_write;
  assign ex_mem_write      = ctrl_q.mem_write;
  assign ex_jump           = ctrl_q.jump;
  assign ex_jump_cond      = ctrl_q.jump_cond;
  assign ex_alu_src        = ctrl_q.alu_src;
  assign ex_jump_cond_type = ctrl_q.jump_cond_type;
  assign ex_alu_control    = ctrl_q.alu_control;
  assign ex_result_src     = ctrl_q.result_src;

endmodule

// File: tb/tb_stage_decode_hs.sv
// Directed bench for stage_decode_hs: expected DE/EX contents are queued as
// each input cycle is driven and compared one cycle later.
module tb_stage_decode_hs;

  typedef struct {
    logic        valid;
    logic        ctrl_only;
    logic        reg_write, mem_write, jump, jump_cond, alu_src;
    logic [2:0]  jct, aluc;
    logic [1:0]  rsrc;
    logic [31:0] pc, pc4, imm, rd1, rd2;
    logic [4:0]  rd, rs1, rs2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, de_valid, de_ready, wb_reg_write, ex_clear, ex_ready, ex_valid;
  logic [31:0] de_instr, de_pc, de_pc_plus4, wb_result;
  logic [4:0]  wb_rd;
  logic        ex_reg_write, ex_mem_write, ex_jump, ex_jump_cond, ex_alu_src;
  logic [2:0]  ex_jump_cond_type, ex_alu_control;
  logic [1:0]  ex_result_src;
  logic [31:0] ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2, de_rs1, de_rs2;

  exp_t        exp_q[$];
  logic [31:0] rf_model [32];
  logic [31:0] pc = 32'h100;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  stage_decode_hs dut (
    .clk(clk), .rst(rst), .de_valid(de_valid), .de_ready(de_ready), .de_instr(de_instr),
    .de_pc(de_pc), .de_pc_plus4(de_pc_plus4), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .ex_clear(ex_clear), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_jump(ex_jump),
    .ex_jump_cond(ex_jump_cond), .ex_alu_src(ex_alu_src), .ex_jump_cond_type(ex_jump_cond_type),
    .ex_alu_control(ex_alu_control), .ex_result_src(ex_result_src), .ex_pc(ex_pc),
    .ex_pc_plus_4(ex_pc_plus_4), .ex_imm_ext(ex_imm_ext), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .de_rs1(de_rs1), .de_rs2(de_rs2)
  );

  function automatic logic [31:0] mk_instr(input logic [2:0] op, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [10:0] f11);
    return {f11, rs2, rs1, rd, f3, op};
  endfunction

  function automatic exp_t mk_exp(input logic rw, input logic mw, input logic j, input logic jc,
                                  input logic as, input logic [2:0] jct, input logic [2:0] aluc,
                                  input logic [1:0] rsrc, input logic [31:0] epc,
                                  input logic [31:0] imm, input logic [31:0] rd1,
                                  input logic [31:0] rd2, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2);
    exp_t e;
    e.valid = 1'b1; e.ctrl_only = 1'b0;
    e.reg_write = rw; e.mem_write = mw; e.jump = j; e.jump_cond = jc; e.alu_src = as;
    e.jct = jct; e.aluc = aluc; e.rsrc = rsrc;
    e.pc = epc; e.pc4 = epc + 32'd4; e.imm = imm; e.rd1 = rd1; e.rd2 = rd2;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    return e;
  endfunction

  function automatic exp_t zero_exp(input logic ctrl_only);
    exp_t e;
    e = mk_exp(0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    e.pc4 = 32'd0; e.valid = 1'b0; e.ctrl_only = ctrl_only;
    return e;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic wbw,
                                             input logic [4:0] wrd, input logic [31:0] wres);
    if (idx == 5'd0) return 32'd0;
    if (wbw && wrd == idx) return wres;
    return rf_model[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic wbw,
                               input logic [4:0] wrd, input logic [31:0] wres,
                               input logic clr, input logic rdy, input exp_t e);
    de_valid = v; de_instr = instr; de_pc = pc; de_pc_plus4 = pc + 32'd4;
    wb_reg_write = wbw; wb_rd = wrd; wb_result = wres;
    ex_clear = clr; ex_ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("ex_valid", ex_valid, e.valid);
    chk("ex_reg_write", ex_reg_write, e.reg_write);
    chk("ex_mem_write", ex_mem_write, e.mem_write);
    chk("ex_jump", ex_jump, e.jump);
    chk("ex_jump_cond", ex_jump_cond, e.jump_cond);
    chk("ex_alu_src", ex_alu_src, e.alu_src);
    chk("ex_jump_cond_type", ex_jump_cond_type, e.jct);
    chk("ex_alu_control", ex_alu_control, e.aluc);
    chk("ex_result_src", ex_result_src, e.rsrc);
    if (!e.ctrl_only) begin
      chk("ex_pc", ex_pc, e.pc);
      chk("ex_pc_plus_4", ex_pc_plus_4, e.pc4);
      chk("ex_imm_ext", ex_imm_ext, e.imm);
      chk("ex_rd1", ex_rd1, e.rd1);
      chk("ex_rd2", ex_rd2, e.rd2);
      chk("ex_rd", ex_rd, e.rd);
      chk("ex_rs1", ex_rs1, e.rs1);
      chk("ex_rs2", ex_rs2, e.rs2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    exp_t        e;
    rst = 1'b1; de_valid = 1'b0; de_instr = '0; de_pc = '0; de_pc_plus4 = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0; ex_clear = 1'b0; ex_ready = 1'b1;
    rf_model[0] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex_valid", ex_valid, 1'b0);
    chk("reset_ex_reg_write", ex_reg_write, 1'b0);
    chk("reset_ex_pc", ex_pc, 32'd0);
    chk("reset_ex_rd1", ex_rd1, 32'd0);
    rst = 1'b0;

    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 5'(i), 32'h01010101 * 32'(i), 1'b0, 1'b1, zero_exp(1'b1));
      rf_model[i] = 32'h01010101 * 32'(i);
      checkOutput();
    end

    ins = mk_instr(3'd0, 3'd2, 5'd4, 5'd1, 5'd2, 11'd0);
    e = mk_exp(1, 0, 0, 0, 0, 3'd0, 3'd2, 2'd0, pc, 32'd0,
               model_read(1, 0, 0, 0), model_read(2, 0, 0, 0), 5'd4, 5'd1, 5'd2);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    #1;
    chk("de_ready_idle", de_ready, 1'b1);
    chk("de_rs1", de_rs1, 5'd1);
    chk("de_rs2", de_rs2, 5'd2);
    checkOutput(); pc += 4;

    ins = mk_instr(3'd1, 3'd3, 5'd5, 5'd2, 5'h10, 11'h7FF);
    e = mk_exp(1, 0, 0, 0, 1, 3'd0, 3'd3, 2'd0, pc, 32'hFFFFFFF0,
               model_read(2, 0, 0, 0), model_read(16, 0, 0, 0), 5'd5, 5'd2, 5'h10);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;

    ins = mk_instr(3'd0, 3'd0, 5'd9, 5'd5, 5'd6, 11'd0);
    e = mk_exp(1, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, pc, 32'd0,
               32'hDEADBEEF, model_read(6, 1, 5, 32'hDEADBEEF), 5'd9, 5'd5, 5'd6);
    applyStimulus(1'b1, ins, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, e);
    rf_model[5] = 32'hDEADBEEF;
    checkOutput(); pc += 4;

    ins = mk_instr(3'd3, 3'd0, 5'd3, 5'd1, 5'd2, 11'h400);
    e = mk_exp(0, 1, 0, 0, 1, 3'd0, 3'd0, 2'd0, pc, 32'hFFFF8003,
               model_read(1, 0, 0, 0), model_read(2, 0, 0, 0), 5'd3, 5'd1, 5'd2);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;

    ins = mk_instr(3'd4, 3'd5, 5'd8, 5'd1, 5'd2, 11'd0);
    e = mk_exp(0, 0, 0, 1, 0, 3'd5, 3'd1, 2'd0, pc, 32'd8,
               model_read(1, 0, 0, 0), model_read(2, 0, 0, 0), 5'd8, 5'd1, 5'd2);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;

    ins = mk_instr(3'd5, 3'd0, 5'd1, 5'h10, 5'd0, 11'd0);
    e = mk_exp(1, 0, 1, 0, 0, 3'd0, 3'd0, 2'd2, pc, 32'h10,
               model_read(16, 0, 0, 0), 32'd0, 5'd1, 5'h10, 5'd0);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;

    ins = mk_instr(3'd6, 3'd0, 5'd1, 5'd2, 5'd8, 11'd0);
    e = mk_exp(1, 0, 1, 0, 1, 3'd0, 3'd0, 2'd2, pc, 32'd8,
               model_read(2, 0, 0, 0), model_read(8, 0, 0, 0), 5'd1, 5'd2, 5'd8);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;

    ins = mk_instr(3'd7, 3'd0, 5'd10, 5'd0, 5'd0, 11'd1);
    e = mk_exp(1, 0, 0, 0, 1, 3'd0, 3'd7, 2'd0, pc, 32'h00200000,
               32'd0, 32'd0, 5'd10, 5'd0, 5'd0);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;

    // Load into x3 followed by a consumer of x3
    ins = mk_instr(3'd2, 3'd0, 5'd3, 5'd1, 5'd4, 11'd0);
    e = mk_exp(1, 0, 0, 0, 1, 3'd0, 3'd0, 2'd1, pc, 32'd4,
               model_read(1, 0, 0, 0), model_read(4, 0, 0, 0), 5'd3, 5'd1, 5'd4);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;
    ins = mk_instr(3'd0, 3'd0, 5'd6, 5'd2, 5'd3, 11'd0);
`ifdef DECODE_LOAD_INTERLOCK_EN
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, zero_exp(1'b1));
    #1;
    chk("de_ready_interlock", de_ready, 1'b0);
    checkOutput();
`endif
    e = mk_exp(1, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, pc, 32'd0,
               model_read(2, 0, 0, 0), model_read(3, 0, 0, 0), 5'd6, 5'd2, 5'd3);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    #1;
    chk("de_ready_load_use", de_ready, 1'b1);
    checkOutput(); pc += 4;

    // Backpressure with a writeback to the held instruction's rs2
    ins = mk_instr(3'd0, 3'd1, 5'd8, 5'd1, 5'd7, 11'd0);
    e = mk_exp(1, 0, 0, 0, 0, 3'd0, 3'd1, 2'd0, pc, 32'd0,
               model_read(1, 0, 0, 0), model_read(7, 0, 0, 0), 5'd8, 5'd1, 5'd7);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;
    ins = mk_instr(3'd0, 3'd4, 5'd11, 5'd1, 5'd2, 11'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) e.rd2 = 32'h1234;
      applyStimulus(1'b1, ins, (k == 2), 5'd7, 32'h1234, 1'b0, 1'b0, e);
      #1;
      chk("de_ready_stall", de_ready, 1'b0);
      checkOutput();
    end
    rf_model[7] = 32'h1234;
    e = mk_exp(1, 0, 0, 0, 0, 3'd0, 3'd4, 2'd0, pc, 32'd0,
               model_read(1, 0, 0, 0), model_read(2, 0, 0, 0), 5'd11, 5'd1, 5'd2);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;

    ins = mk_instr(3'd0, 3'd0, 5'd13, 5'd1, 5'd2, 11'd0);
    applyStimulus(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, zero_exp(1'b0));
    checkOutput(); pc += 4;

    applyStimulus(1'b0, 32'd0, 1'b1, 5'd0, 32'd5, 1'b0, 1'b1, zero_exp(1'b1));
    checkOutput();
    ins = mk_instr(3'd0, 3'd0, 5'd12, 5'd0, 5'd0, 11'd0);
    e = mk_exp(1, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, pc, 32'd0,
               32'd0, 32'd0, 5'd12, 5'd0, 5'd0);
    applyStimulus(1'b1, ins, 1'b1, 5'd0, 32'hAAAA5555, 1'b0, 1'b1, e);
    checkOutput(); pc += 4;

    // Asynchronous reset between edges while EX holds a live instruction
    de_valid = 1'b0; wb_reg_write = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ex_valid", ex_valid, 1'b0);
    chk("async_rst_ex_reg_write", ex_reg_write, 1'b0);
    chk("async_rst_ex_pc", ex_pc, 32'd0);
    chk("async_rst_ex_pc_plus_4", ex_pc_plus_4, 32'd0);
    chk("async_rst_ex_rd", ex_rd, 5'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
